// File: rtl/rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Package : rs_gf_pkg
// Purpose : GF(2^10) arithmetic shared by the RS(128,116) decoder stages.
//           Field generated by the primitive polynomial x^10 + x^3 + 1.
// Revision: 1.0 - initial release
// ============================================================================
package rs_gf_pkg;

  localparam int GF_M = 10;
  // Low-order terms of the primitive polynomial (x^10 folds back onto x^3+1)
  localparam logic [GF_M-1:0] GF_POLY_LO = 10'h009;

  // Shift-and-add multiply with modular reduction after every shift.
  // With one operand constant this collapses to a small XOR network.
  function automatic logic [GF_M-1:0] MULTGF(input logic [GF_M-1:0] a,
                                             input logic [GF_M-1:0] b);
    logic [GF_M-1:0] p;
    logic [GF_M-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[GF_M-2:0], 1'b0} ^ (x[GF_M-1] ? GF_POLY_LO : '0);
    end
    return p;
  endfunction

  // alpha^n, built by repeated multiplication by alpha (= x); used only at
  // elaboration time to derive the Horner constants.
  function automatic logic [GF_M-1:0] alpha_pow(input int n);
    logic [GF_M-1:0] r;
    r = {{(GF_M-1){1'b0}}, 1'b1};
    for (int i = 0; i < n; i++) begin
      r = MULTGF(r, {{(GF_M-2){1'b0}}, 2'b10});
    end
    return r;
  endfunction

endpackage

// ============================================================================
// Module  : rs_syndrome_calc
// Purpose : Syndrome front end of the RS(128,116) decoder over GF(2^10).
//           Evaluates S_j = r(alpha^(FCR+j-1)), j = 1..2T, by Horner's rule
//           on a codeword streamed highest-degree symbol first, and hands the
//           syndrome vector downstream through a valid/ready register.
// Ports   : clk, rst        - clock (rising edge), synchronous active-high reset
//           in_data/_valid  - received symbol stream
//           in_sop          - first symbol of a codeword (qualified by valid)
//           in_ready        - symbol accepted this cycle (state-only)
//           synd_data       - 2T syndromes, S_1 in the low PREST bits
//           synd_valid/_ready - output handshake, data held until accepted
//           synd_nz         - OR of all syndromes (0 = error-free codeword)
//           sop_err         - one-cycle pulse when a codeword is aborted by
//                             an early in_sop
// Revision: 1.0 - initial release
// ============================================================================
module rs_syndrome_calc
  import rs_gf_pkg::*;
#(
  parameter int N     = 128,
  parameter int K     = 116,
  parameter int PREST = 10,
  parameter int FCR   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PREST-1:0]               in_data,
  input  logic                           in_valid,
  input  logic                           in_sop,
  output logic                           in_ready,
  output logic [2*((N-K)/2)*PREST-1:0]   synd_data,
  output logic                           synd_valid,
  input  logic                           synd_ready,
  output logic                           synd_nz,
  output logic                           sop_err
);

  localparam int T    = (N - K) / 2;
  localparam int NSYN = 2 * T;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] C_N = 8'(N);

  logic [1:0]                        state_q, state_d;
  logic [7:0]                        cnt_q, cnt_d;
  logic [NSYN-1:0][PREST-1:0]        acc_q, acc_d;
  logic [NSYN-1:0][PREST-1:0]        horner_w;
  logic [NSYN*PREST-1:0]             synd_data_q, synd_data_d;
  logic                              synd_valid_q, synd_valid_d;
  logic                              synd_nz_q, synd_nz_d;
  logic                              sop_err_q, sop_err_d;
  logic                              accept_w;

  // in_ready depends on the registered state only
  assign in_ready = (state_q != S_DONE);
  assign accept_w = in_valid & in_ready;

  // One Horner step per syndrome: acc * alpha^(FCR+j-1) + r_i
  for (genvar j = 0; j < NSYN; j++) begin : g_horner
    localparam logic [PREST-1:0] C_ALPHA = alpha_pow(FCR + j);
    assign horner_w[j] = MULTGF(acc_q[j], C_ALPHA) ^ in_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    synd_data_d  = synd_data_q;
    synd_valid_d = synd_valid_q;
    synd_nz_d    = synd_nz_q;
    sop_err_d    = 1'b0;

    // Output register empties on handshake unless DONE refills it below
    if (synd_valid_q && synd_ready) synd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_w && in_sop) begin
          acc_d   = {NSYN{in_data}};
          cnt_d   = 8'd1;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (accept_w) begin
          if (in_sop) begin
            // Early start of a new codeword: drop the partial one
            sop_err_d = 1'b1;
            acc_d     = {NSYN{in_data}};
            cnt_d     = 8'd1;
          end else begin
            acc_d = horner_w;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == C_N) state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!synd_valid_q || synd_ready) begin
          synd_data_d  = acc_q;
          synd_valid_d = 1'b1;
          synd_nz_d    = |acc_q;
          cnt_d        = 8'd0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      acc_q        <= '0;
      synd_data_q  <= '0;
      synd_valid_q <= 1'b0;
      synd_nz_q    <= 1'b0;
      sop_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      synd_data_q  <= synd_data_d;
      synd_valid_q <= synd_valid_d;
      synd_nz_q    <= synd_nz_d;
      sop_err_q    <= sop_err_d;
    end
  end

  assign synd_data  = synd_data_q;
  assign synd_valid = synd_valid_q;
  assign synd_nz    = synd_nz_q;
  assign sop_err    = sop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs_syndrome_calc
// Purpose : Self-checking bench for rs_syndrome_calc. Stimulus pushes the
//           expected {synd_nz, synd_data} into a queue; a monitor pops and
//           compares on every output handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_calc;

  localparam int N  = 128;
  localparam int NS = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    in_data;
  logic          in_valid;
  logic          in_sop;
  logic          in_ready;
  logic [119:0]  synd_data;
  logic          synd_valid;
  logic          synd_ready;
  logic          synd_nz;
  logic          sop_err;

  always #5 clk = ~clk;

  rs_syndrome_calc dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_ready   (in_ready),
    .synd_data  (synd_data),
    .synd_valid (synd_valid),
    .synd_ready (synd_ready),
    .synd_nz    (synd_nz),
    .sop_err    (sop_err)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           sop_pulses = 0;
  logic [120:0] exp_q [$];
  logic [9:0]   cw [N];      // indexed by polynomial degree
  logic [9:0]   exp_s [NS];  // exp_s[j-1] = S_j
  logic [9:0]   g [13];
  logic         held_v = 1'b0;
  logic [120:0] held;

  // Polynomial product followed by reduction modulo x^10 + x^3 + 1
  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
    logic [18:0] p;
    p = '0;
    for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (19'(a) << i);
    for (int k = 18; k >= 10; k--) if (p[k]) p = p ^ (19'h409 << (k - 10));
    return p[9:0];
  endfunction

  function automatic logic [9:0] gf_pow(input int n);
    logic [9:0] r;
    r = 10'h001;
    for (int i = 0; i < n; i++) r = gf_mul(r, 10'h002);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp();
    logic [119:0] d;
    for (int j = 0; j < NS; j++) d[j*10 +: 10] = exp_s[j];
    exp_q.push_back({|d, d});
  endtask

  task automatic clear_cw();
    for (int i = 0; i < N; i++) cw[i] = 10'h000;
  endtask

  // Expected syndromes from an error pattern alone: S_j = sum e * alpha^(j*d)
  task automatic exp_from_errors(input int d0, input logic [9:0] e0,
                                 input int d1, input logic [9:0] e1,
                                 input int d2, input logic [9:0] e2);
    for (int j = 1; j <= NS; j++) begin
      exp_s[j-1] = gf_mul(e0, gf_pow(j*d0)) ^ gf_mul(e1, gf_pow(j*d1)) ^
                   gf_mul(e2, gf_pow(j*d2));
    end
  endtask

  task automatic send_sym(input logic [9:0] d, input logic sop);
    int c;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    c = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      c++;
      if (c > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_cw();
    for (int k = 0; k < N; k++) send_sym(cw[N-1-k], k == 0);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on handshake, check hold stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (sop_err) sop_pulses++;
      if (synd_valid) begin
        if (held_v) chk("hold_stable", {synd_nz, synd_data}, held);
        if (synd_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h with no expected entry", {synd_nz, synd_data});
          end else begin
            chk("syndromes", {synd_nz, synd_data}, exp_q.pop_front());
          end
        end else begin
          held_v = 1'b1;
          held   = {synd_nz, synd_data};
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = '0; synd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_synd_valid", synd_valid, 0);
    chk("rst_synd_data",  synd_data,  0);
    chk("rst_synd_nz",    synd_nz,    0);
    chk("rst_sop_err",    sop_err,    0);
    rst = 1'b0;

    // Generator polynomial g(x) = prod_{j=1..12} (x + alpha^j)
    for (int i = 0; i < 13; i++) g[i] = 10'h000;
    g[0] = 10'h001;
    for (int j = 1; j <= NS; j++) begin
      for (int i = 12; i >= 1; i--) g[i] = g[i-1] ^ gf_mul(g[i], gf_pow(j));
      g[0] = gf_mul(g[0], gf_pow(j));
    end

    // 1: all-zero codeword, plus one-cycle latency check
    clear_cw();
    for (int j = 0; j < NS; j++) exp_s[j] = 10'h000;
    push_exp();
    send_cw();
    chk("lat_done_valid", synd_valid, 0);
    chk("lat_done_ready", in_ready,   0);
    @(posedge clk);
    #1;
    chk("lat_valid_next", synd_valid, 1);

    // 2: single 1 at degree 0
    clear_cw();
    cw[0] = 10'h001;
    for (int j = 0; j < NS; j++) exp_s[j] = 10'h001;
    push_exp();
    send_cw();

    // 3: single 1 at degree 1 -> alpha^j
    clear_cw();
    cw[1] = 10'h001;
    exp_s = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
              10'h080, 10'h100, 10'h200, 10'h009, 10'h012, 10'h024};
    push_exp();
    send_cw();

    // 4: valid codeword (combination of shifted g(x)) -> all zero
    clear_cw();
    for (int i = 0; i < 13; i++) begin
      cw[i+20]  = cw[i+20]  ^ g[i];
      cw[i+3]   = cw[i+3]   ^ gf_mul(10'h155, g[i]);
      cw[i+100] = cw[i+100] ^ gf_mul(10'h2C7, g[i]);
    end
    for (int j = 0; j < NS; j++) exp_s[j] = 10'h000;
    push_exp();
    send_cw();

    // 5: same codeword with three symbol errors
    cw[5]   = cw[5]   ^ 10'h3A1;
    cw[77]  = cw[77]  ^ 10'h0F0;
    cw[120] = cw[120] ^ 10'h155;
    exp_from_errors(5, 10'h3A1, 77, 10'h0F0, 120, 10'h155);
    push_exp();
    send_cw();
    wait_drain();

    // 6: output stalled while a second codeword completes
    synd_ready = 1'b0;
    clear_cw();
    cw[0] = 10'h001;
    for (int j = 0; j < NS; j++) exp_s[j] = 10'h001;
    push_exp();
    send_cw();
    clear_cw();
    cw[1] = 10'h001;
    exp_s = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
              10'h080, 10'h100, 10'h200, 10'h009, 10'h012, 10'h024};
    push_exp();
    send_cw();
    repeat (20) @(posedge clk);
    #1;
    chk("stall_in_ready",   in_ready,   0);
    chk("stall_synd_valid", synd_valid, 1);
    synd_ready = 1'b1;
    wait_drain();

    // 7: early in_sop at symbol 50 restarts the codeword
    for (int k = 0; k < 50; k++) send_sym(10'(10'h3C5 ^ k), k == 0);
    clear_cw();
    cw[7]  = 10'h0AB;
    cw[90] = 10'h301;
    exp_from_errors(7, 10'h0AB, 90, 10'h301, 0, 10'h000);
    push_exp();
    send_cw();
    wait_drain();
    chk("sop_err_pulses", sop_pulses, 1);

    // 8: reset at symbol 60, then a fresh codeword
    for (int k = 0; k < 60; k++) send_sym(10'(10'h1F3 + k), k == 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready",   in_ready,   1);
    chk("midrst_synd_valid", synd_valid, 0);
    chk("midrst_synd_data",  synd_data,  0);
    chk("midrst_synd_nz",    synd_nz,    0);
    chk("midrst_sop_err",    sop_err,    0);
    rst = 1'b0;
    clear_cw();
    cw[2]   = 10'h011;
    cw[64]  = 10'h2E0;
    cw[127] = 10'h3FF;
    exp_from_errors(2, 10'h011, 64, 10'h2E0, 127, 10'h3FF);
    push_exp();
    send_cw();
    wait_drain();
    chk("sop_err_after_rst", sop_pulses, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Front-end stage of the RS(128,116) decoder over GF(2^10), primitive polynomial x^10+x^3+1, T=6. Sits directly upstream of the RiBM key-equation solver.
- Consumes a received codeword one symbol per cycle, highest-degree symbol first.
- Computes the 2T=12 syndromes S_j = r(alpha^j), j=1..12, by Horner's rule.
- Hands the syndrome vector to RiBM through a valid/ready handshake.
- All GF multiplies use the package MULTGF function with constant operands alpha^j.

Parameters:
- N, 128: codeword length in symbols.
- K, 116: message length in symbols.
- T, (N-K)/2 = 6: correctable symbols. The block produces 2T syndromes.
- PREST, 10: symbol width in bits (GF(2^10)).
- FCR, 1: first consecutive root. Syndrome j is evaluated at alpha^(FCR+j-1).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_data, in, PREST: received symbol.
- in_valid, in, 1: in_data valid.
- in_sop, in, 1: marks the first symbol of a codeword. Qualified by in_valid.
- in_ready, out, 1: block accepts a symbol this cycle.
- synd_data, out, 2T*PREST: syndromes. S_1 sits in bits [PREST-1:0]; S_j sits in bits [j*PREST-1:(j-1)*PREST].
- synd_valid, out, 1: synd_data valid. Held until accepted.
- synd_ready, in, 1: RiBM accepts the syndromes.
- synd_nz, out, 1: OR of all syndromes, valid with synd_valid. 0 means the codeword is error-free.
- sop_err, out, 1: single-cycle pulse when a codeword is aborted by an early in_sop.

Behaviour:
- Reset values: in_ready=1, synd_valid=0, synd_data=0, synd_nz=0, sop_err=0. Reset also clears the accumulators, clears the counter and sets state to IDLE. Reset mid-codeword discards the partial codeword and any pending output.
- A symbol is accepted when in_valid & in_ready.
- FSM states:
  - IDLE: in_ready=1. Symbols accepted without in_sop are dropped. An accepted symbol with in_sop loads acc_j <= in_data for all j, sets cnt <= 1, and moves to ACCUM.
  - ACCUM: in_ready=1. Each accepted symbol does acc_j <= MULTGF(acc_j, alpha^(FCR+j-1)) ^ in_data, and cnt <= cnt+1. On the symbol that makes cnt=N the FSM moves to DONE.
  - DONE: in_ready=0. When the output register is empty, or is being emptied this cycle (synd_valid & synd_ready), copy acc to synd_data, set synd_valid=1 and synd_nz=|acc, and go to IDLE.
- Early in_sop in ACCUM (cnt < N): pulse sop_err=1 for one cycle, discard the partial result, and restart with this symbol as the first symbol (acc_j <= in_data, cnt <= 1). This is not an error in IDLE.
- Latency: last symbol accepted at cycle t gives synd_valid=1 at t+1 when the output register is free. If the output register is stalled, the block stays in DONE with in_ready=0 until synd_ready frees it.
- Throughput: with synd_ready tied high, back-to-back codewords lose exactly one cycle per codeword (the DONE cycle).
- Output register: synd_valid drops on the cycle after synd_valid & synd_ready unless DONE reloads it in that same cycle. synd_data and synd_nz are stable while synd_valid=1 and synd_ready=0.
- cnt is 8 bits wide, counts 1..N, and wraps to 0 on leaving DONE.
- Constants alpha^1..alpha^12 are built with MULTGF in elaboration-time functions, never as hard-coded literals. Example values: alpha^10 = 0x009, alpha^11 = 0x012, alpha^12 = 0x024.
- No combinational path from in_valid or synd_ready to in_ready except through the registered state. in_ready is a function of state only.

Test Plan:
- All-zero codeword, synd_ready=1 -> one cycle after the 128th symbol: synd_valid=1, all S_j=0x000, synd_nz=0.
- Zero codeword except last symbol (degree 0) = 0x001 -> all twelve S_j=0x001, synd_nz=1.
- Zero codeword except symbol 127 (degree 1) = 0x001 -> S_1..S_9 = 0x002, 0x004, ... 0x200; S_10=0x009, S_11=0x012, S_12=0x024.
- Valid RS codeword from the golden encoder, then the same word with 3 random symbol errors -> first: all zero, synd_nz=0. Second: syndromes match the software model.
- synd_ready=0 for 20 cycles while a second codeword completes -> first output held stable. Second codeword stalls in DONE with in_ready=0. Both outputs delivered in order and correct once synd_ready=1.
- in_sop at symbol 50 of a codeword; separately, rst asserted at symbol 60 -> sop_err pulses once and the restarted codeword's syndromes are correct. After rst: all outputs at reset values, and the next codeword is processed correctly.
